// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response plus the hand-off to the control unit.
// The master modport is the fetch unit; the slave modport is the memory/core side.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7;
    logic        pc_src;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_addr, instr, instr_valid, op, funct3, funct7,
               pc, pc_plus4, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, imm_ext
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr, instr_valid, op, funct3, funct7,
               pc, pc_plus4, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, pc_src, imm_ext
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time, holds the instruction
// until the core accepts it. Define FETCH_MISALIGN_TRAP_EN to trap misaligned branch targets.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        started_q;
    logic        fault_q;
    logic [31:0] pc_plus4;
    logic [31:0] br_sum;
    logic        req_valid;
    logic        instr_valid;

    assign pc_plus4 = pc_q + 32'd4;
    assign br_sum   = pc_q + bus.imm_ext;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_d;
`else
    assign fault_q = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        req_valid   = 1'b0;
        instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d     = fault_q;
`endif
        unique case (state_q)
            S_REQ: begin
                // started_q keeps the request low until the first edge after reset release
                req_valid = started_q;
                if (started_q && bus.imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.imem_rsp_valid) begin
                    instr_d = bus.imem_rsp_data;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    state_d = S_REQ;
                    if (bus.pc_src) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (br_sum[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            pc_d = br_sum;
                        end
`else
                        pc_d = br_sum & ~32'h3;
`endif
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            instr_q   <= 32'h0000_0013;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            started_q <= 1'b1;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
`endif

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.instr          = instr_q;
    assign bus.instr_valid    = instr_valid;
    assign bus.op             = instr_q[6:0];
    assign bus.funct3         = instr_q[14:12];
    assign bus.funct7         = instr_q[30];
    assign bus.pc             = pc_q;
    assign bus.pc_plus4       = pc_plus4;
    assign bus.fetch_fault    = fault_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential and branch fetch, backpressure,
// misaligned branch target (both FETCH_MISALIGN_TRAP_EN builds) and reset mid-transaction.
module tb_fetch_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at a negedge where a request is expected; returns at a negedge in S_HOLD.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        check("req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check("req_addr", bus.imem_addr, addr);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("wait_req_low", {31'b0, bus.imem_req_valid}, 32'd0);
        check("wait_no_valid", {31'b0, bus.instr_valid}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
        check("hold_instr", bus.instr, data);
    endtask

    task automatic accept(input logic src, input logic [31:0] imm);
        bus.instr_ready = 1'b1;
        bus.pc_src      = src;
        bus.imm_ext     = imm;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        bus.pc_src      = 1'b0;
        bus.imm_ext     = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, bus.pc, 32'h100);
        check({tag, "_instr"}, bus.instr, 32'h13);
        check({tag, "_instr_valid"}, {31'b0, bus.instr_valid}, 32'd0);
        check({tag, "_req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
        check({tag, "_fault"}, {31'b0, bus.fetch_fault}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.pc_src         = 1'b0;
        bus.imm_ext        = 32'h0;

        // Reset and first fetch
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        rst_n = 1'b1;
        check("req_low_before_edge", {31'b0, bus.imem_req_valid}, 32'd0);
        @(negedge clk);
        fetch(32'h100, 32'h0020_8133);
        check("op0", {25'b0, bus.op}, 32'h33);
        check("funct3_0", {29'b0, bus.funct3}, 32'h0);
        check("funct7_0", {31'b0, bus.funct7}, 32'h0);
        check("pc0", bus.pc, 32'h100);
        check("pc_plus4_0", bus.pc_plus4, 32'h104);

        // Sequential: next request lands 3 cycles after the previous one
        accept(1'b0, 32'h0);
        fetch(32'h104, 32'h4000_7013);
        check("op1", {25'b0, bus.op}, 32'h13);
        check("funct3_1", {29'b0, bus.funct3}, 32'h7);
        check("funct7_1", {31'b0, bus.funct7}, 32'h1);

        // Taken backward branch
        accept(1'b1, 32'hFFFF_FFF8);

        // Request backpressure
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
            check("bp_req_addr", bus.imem_addr, 32'h0FC);
            @(negedge clk);
        end
        fetch(32'h0FC, 32'h0000_0093);

        // Core backpressure with a spurious response during S_HOLD
        for (int i = 0; i < 5; i++) begin
            bus.imem_rsp_valid = (i == 2);
            bus.imem_rsp_data  = 32'hDEAD_BEEF;
            bus.instr_ready    = 1'b0;
            @(negedge clk);
            check("hold_bp_instr", bus.instr, 32'h0000_0093);
            check("hold_bp_pc", bus.pc, 32'h0FC);
            check("hold_bp_valid", {31'b0, bus.instr_valid}, 32'd1);
        end
        bus.imem_rsp_valid = 1'b0;
        accept(1'b1, 32'h0000_0104);
        fetch(32'h200, 32'h0000_0013);

        // Misaligned branch target
        accept(1'b1, 32'h0000_0006);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", {31'b0, bus.fetch_fault}, 32'd1);
        check("mis_pc", bus.pc, 32'h200);
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mis_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
            check("mis_no_valid", {31'b0, bus.instr_valid}, 32'd0);
            @(negedge clk);
        end
        bus.imem_req_ready = 1'b0;
        check("mis_fault_sticky", {31'b0, bus.fetch_fault}, 32'd1);
`else
        check("mis_fault", {31'b0, bus.fetch_fault}, 32'd0);
        check("mis_addr", bus.imem_addr, 32'h204);
        check("mis_req", {31'b0, bus.imem_req_valid}, 32'd1);
`endif

        // Re-initialise, then steer to 0x3C and reset while waiting for the response
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h100, 32'h0000_0013);
        accept(1'b1, 32'hFFFF_FF3C);
        check("pre_rst_addr", bus.imem_addr, 32'h03C);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("pre_rst_wait", {31'b0, bus.imem_req_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_0BAD;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("post_rst_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("post_rst_addr", bus.imem_addr, 32'h100);
        check("post_rst_instr", bus.instr, 32'h13);
        check("post_rst_no_valid", {31'b0, bus.instr_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the control unit. It owns the program counter, issues word fetches to instruction memory over a valid/ready request and response-valid handshake, and holds each fetched instruction stable until the core accepts it. It presents the decoded opcode, funct3 and funct7[5] fields to the control unit, and consumes the control unit's branch decision (`pc_src`) together with the extended immediate to select the next PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded at reset; must be word-aligned.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request this cycle.
- `imem_addr` output 32: fetch address; always equals `pc`.
- `imem_rsp_valid` input 1: response data valid.
- `imem_rsp_data` input 32: fetched instruction word.
- `instr` output 32: held instruction.
- `instr_valid` output 1: `instr` and the decoded fields are valid.
- `instr_ready` input 1: core consumes the instruction this cycle.
- `op` output 7: `instr[6:0]`.
- `funct3` output 3: `instr[14:12]`.
- `funct7` output 1: `instr[30]`.
- `pc_src` input 1: branch taken; sampled only on the `instr_valid & instr_ready` cycle.
- `imm_ext` input 32: sign-extended branch offset; sampled with `pc_src`.
- `pc` output 32: address of the current or held instruction.
- `pc_plus4` output 32: `pc + 4`, combinational.
- `fetch_fault` output 1: misaligned branch target (see Configuration).

## Operation
- State machine states: S_REQ, S_WAIT, S_HOLD, S_FAULT.
- **S_REQ**
  - Drives `imem_req_valid=1` and `imem_addr=pc`.
  - Moves to S_WAIT when `imem_req_ready=1`.
  - Otherwise holds the request and address stable.
- **S_WAIT**
  - Drives `imem_req_valid=0`.
  - When `imem_rsp_valid=1`: loads `instr <= imem_rsp_data` and moves to S_HOLD.
- **S_HOLD**
  - Drives `instr_valid=1`; `instr` and `pc` are held stable.
  - When `instr_ready=1`, computes the next PC:
    - `pc_src=1`: `pc <= pc + imm_ext`.
    - `pc_src=0`: `pc <= pc + 4`.
    - Then moves to S_REQ.
- **S_FAULT**: terminal state. All request and valid outputs are 0; leaves only on reset.
- `imem_rsp_valid` is ignored outside S_WAIT (no capture, no state change).
- Arithmetic:
  - All additions are 32-bit modulo 2^32.
  - PC wrap-around from 32'hFFFF_FFFC to 32'h0000_0000 is legal and unflagged.
- Decoded fields are driven from `instr` continuously. They are meaningful only while `instr_valid=1`.
- Exactly one outstanding request at any time.

## Timing
- Reset values (asynchronous, while `rst_n=0`):
  - `pc = RESET_PC`, `instr = 32'h0000_0013` (NOP), `instr_valid = 0`, `imem_req_valid = 0`, `fetch_fault = 0`.
  - State is S_REQ.
- First request: `imem_req_valid` rises on the first clock edge after `rst_n` deasserts.
- Latency with zero-wait memory: one instruction per 3 cycles.
  - REQ accepted in cycle N.
  - Response in cycle N+1.
  - `instr_valid` in cycle N+2.
  - Accepted in N+2, so the next REQ is in N+3.
- The response must arrive no earlier than the cycle after request acceptance.
- Reset mid-transaction:
  - Any outstanding request is abandoned and a late response is ignored.
  - Memory must tolerate the abandoned request.
- `instr_ready` while `instr_valid=0` has no effect.
- `pc` changes only on the S_HOLD handshake edge.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` **defined**:
  - At the S_HOLD handshake with `pc_src=1`, if `(pc + imm_ext)[1:0] != 2'b00`:
    - `pc` is not updated.
    - `fetch_fault` is set (sticky) and the state moves to S_FAULT.
- `FETCH_MISALIGN_TRAP_EN` **undefined**:
  - Branch-target bits [1:0] are forced to 2'b00.
  - `fetch_fault` is tied to 0.
  - S_FAULT is unreachable.

## Test plan
- **Reset/first fetch.** `RESET_PC=32'h100`; release `rst_n`; `imem_req_ready=1`; respond 32'h0020_8133 next cycle.
  - Expect `imem_addr=32'h100`.
  - Expect `instr_valid=1`, `op=7'h33`, `funct3=0`, `funct7=0`, `pc=32'h100`.
- **Sequential.** Accept with `pc_src=0`.
  - Expect the next request at 32'h104.
  - Expect a 3-cycle cadence with zero-wait memory.
- **Taken branch.** `pc=32'h104`, `pc_src=1`, `imm_ext=32'hFFFF_FFF8`.
  - Expect the next `imem_addr=32'hFC`.
- **Backpressure.**
  - Hold `imem_req_ready=0` for 4 cycles: request and address stay stable.
  - Hold `instr_ready=0` for 5 cycles: `instr` and `pc` stay stable.
  - Inject a spurious `imem_rsp_valid` during S_HOLD: `instr` is unchanged.
- **Misalign.** `pc=32'h200`, `pc_src=1`, `imm_ext=32'h6`.
  - With `FETCH_MISALIGN_TRAP_EN`: `fetch_fault=1`, `pc=32'h200`, no further requests.
  - Without it: next address 32'h204.
- **Reset mid-operation.** Assert `rst_n=0` in S_WAIT at `pc=32'h3C`.
  - All outputs return to their reset values immediately.
  - A response arriving after the release is ignored.
  - The first request after release is to `RESET_PC`.
